m_vec_checker: RTL
==================

Name: m_vec_checker

Overview:
- Response-side counterpart of the gate stimulus benches. It accepts a stream of (a, b, s) result vectors from a 2-input gate DUT and compares each s against the expected truth-table value.
- It counts passes and failures, captures the first failing vector, and reports a final verdict after N_VEC vectors.
- It sits on the DUT output side in both the on-FPGA self-test and the simulation top.

Parameters:
- N_VEC, 4, number of vectors per run (1..2^CNT_W-1).
- FUNC, 1, expected function: 0=AND, 1=OR, 2=XOR, 3=NAND.
- CNT_W, 8, width of counters and index.
- TIMEOUT, 16, idle-cycle limit in RUN. Used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin a run; sampled in IDLE or DONE.
- in_valid  in  1  vector present on a/b/s.
- in_ready  out  1  checker can accept a vector.
- a  in  1  DUT input a of the vector.
- b  in  1  DUT input b of the vector.
- s  in  1  DUT output for (a, b).
- busy  out  1  high in RUN.
- done  out  1  high in DONE, held until the next start.
- pass  out  1  verdict; meaningful only while done=1.
- timeout  out  1  run ended by watchdog.
- pass_cnt  out  CNT_W  matching vectors.
- fail_cnt  out  CNT_W  mismatching vectors.
- first_fail  out  3  {a, b, s} of the first mismatch; 0 if none.
- first_fail_idx  out  CNT_W  index (0-based) of the first mismatch; 0 if none.

Behaviour:
- The design uses one clock. Reset is synchronous and active-high.
- Reset: state returns to IDLE. All outputs go to 0, including in_ready. Reset wins over every other input, including mid-run; a partial run is discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start=1.
  - RUN -> DONE on acceptance of vector index N_VEC-1 (or on timeout, if the feature is compiled in).
  - DONE -> RUN on start=1.
- Start behaviour:
  - start is ignored while in RUN.
  - Entering RUN clears pass_cnt, fail_cnt, first_fail, first_fail_idx, timeout and the internal index, all in the same edge.
- Handshake:
  - in_ready = 1 only in RUN (combinational from state).
  - A vector is accepted on a rising edge where in_valid && in_ready.
  - in_ready is 0 during the cycle start is sampled. A vector offered in that cycle is not accepted; the source holds it.
  - in_valid without in_ready has no effect.
- Check of an accepted vector:
  - expected = f(a, b) per FUNC; mismatch = (s != expected).
  - On a match, pass_cnt increments. On a mismatch, fail_cnt increments.
  - On the first mismatch of the run, first_fail <= {a, b, s} and first_fail_idx <= current index.
  - The index increments on every accept.
- Latency:
  - Counters and first_fail* update on the edge of acceptance and are visible in the next cycle.
  - done and pass rise one cycle after the final accept edge.
  - busy falls in that same cycle.
- Verdict: pass = (fail_cnt == 0) && !timeout, registered on entry to DONE.
- Counters saturate at 2^CNT_W-1 and never wrap. The index cannot exceed N_VEC-1 by construction.
- Illegal FUNC values behave as 0 (AND). Illegal FSM state encodings return to IDLE.

Optional Feature:
- Macro: VEC_CHECKER_TIMEOUT_EN.
- With the macro defined:
  - A watchdog counter clears on every accept and on RUN entry, and increments on each RUN cycle without an accept.
  - When it reaches TIMEOUT, the block goes RUN -> DONE on that edge, with timeout <= 1 and pass <= 0.
  - Counters keep their partial values.
- Without the macro: no watchdog logic is built, timeout is tied to 0, and RUN waits indefinitely.

Test Plan:
- rst=1, 2 cycles -> all outputs 0, in_ready=0. Then start pulse -> in_ready=1 the next cycle, busy=1.
- FUNC=1, N_VEC=4, vectors 00/0, 01/1, 10/1, 11/1 back-to-back -> pass_cnt=4, fail_cnt=0, done=1 and pass=1 one cycle after the 4th accept.
- FUNC=1, vector 01 with s=0 (faulty DUT) as index 1, and 11 with s=0 as index 3 -> fail_cnt=2, pass_cnt=2, first_fail=3'b010, first_fail_idx=1, pass=0.
- in_valid toggled every other cycle, and in_valid asserted in the start cycle -> only vectors offered while in_ready=1 are counted; totals equal 4 exactly. A second start during RUN is ignored.
- rst asserted after 2 accepts -> next cycle all outputs 0, state IDLE. A new start yields a clean run with totals 4/0.
- With VEC_CHECKER_TIMEOUT_EN, TIMEOUT=16: 2 accepts, then in_valid=0 for 16 cycles -> done=1, timeout=1, pass=0, pass_cnt=2. Without the macro, the same stimulus leaves busy=1 and timeout=0.

Source files
------------

// File: rtl/m_vec_checker.sv
// Response checker for a 2-input gate DUT: compares (a, b, s) vectors against a truth table,
// counts passes/fails, records the first failure. Optional watchdog: VEC_CHECKER_TIMEOUT_EN.
module m_vec_checker #(
   parameter int unsigned N_VEC   = 4,
   parameter int unsigned FUNC    = 1,
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             a,
   input  logic             b,
   input  logic             s,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             timeout,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic [2:0]       first_fail,
   output logic [CNT_W-1:0] first_fail_idx
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   localparam logic [CNT_W-1:0] LastIdx = CNT_W'(N_VEC - 1);

   if (N_VEC < 1 || N_VEC > (2 ** CNT_W) - 1 || TIMEOUT < 1) begin : g_bad_params
      $error("m_vec_checker: parameter out of range");
   end

   state_e           state_q, state_d;
   logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
   logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
   logic [2:0]       first_fail_q, first_fail_d;
   logic [CNT_W-1:0] first_fail_idx_q, first_fail_idx_d;
   logic [CNT_W-1:0] idx_q, idx_d;
   logic             pass_q, pass_d;
   logic             expected;
   logic             mismatch;

`ifdef VEC_CHECKER_TIMEOUT_EN
   localparam int unsigned WdW = $clog2(TIMEOUT + 1);
   logic [WdW-1:0] wd_q, wd_d;
   logic           timeout_q, timeout_d;
   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   // Unsupported FUNC codes fall back to AND.
   always_comb begin
      case (FUNC)
         1:       expected = a | b;
         2:       expected = a ^ b;
         3:       expected = ~(a & b);
         default: expected = a & b;
      endcase
   end

   assign mismatch = (s != expected);

   always_comb begin
      state_d          = state_q;
      pass_cnt_d       = pass_cnt_q;
      fail_cnt_d       = fail_cnt_q;
      first_fail_d     = first_fail_q;
      first_fail_idx_d = first_fail_idx_q;
      idx_d            = idx_q;
      pass_d           = pass_q;
`ifdef VEC_CHECKER_TIMEOUT_EN
      wd_d             = wd_q;
      timeout_d        = timeout_q;
`endif
      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d          = StRun;
               pass_cnt_d       = '0;
               fail_cnt_d       = '0;
               first_fail_d     = '0;
               first_fail_idx_d = '0;
               idx_d            = '0;
               pass_d           = 1'b0;
`ifdef VEC_CHECKER_TIMEOUT_EN
               wd_d             = '0;
               timeout_d        = 1'b0;
`endif
            end
         end
         StRun: begin
            if (in_valid) begin
               if (mismatch) begin
                  if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNT_W'(1);
                  if (fail_cnt_q == '0) begin
                     first_fail_d     = {a, b, s};
                     first_fail_idx_d = idx_q;
                  end
               end else if (pass_cnt_q != '1) begin
                  pass_cnt_d = pass_cnt_q + CNT_W'(1);
               end
               // The verdict uses the post-accept fail count so it is valid as done rises.
               if (idx_q == LastIdx) begin
                  state_d = StDone;
                  pass_d  = (fail_cnt_d == '0);
               end else begin
                  idx_d = idx_q + CNT_W'(1);
               end
`ifdef VEC_CHECKER_TIMEOUT_EN
               wd_d = '0;
            end else if (wd_q == WdW'(TIMEOUT - 1)) begin
               state_d   = StDone;
               timeout_d = 1'b1;
               pass_d    = 1'b0;
            end else begin
               wd_d = wd_q + WdW'(1);
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= StIdle;
         pass_cnt_q       <= '0;
         fail_cnt_q       <= '0;
         first_fail_q     <= '0;
         first_fail_idx_q <= '0;
         idx_q            <= '0;
         pass_q           <= 1'b0;
`ifdef VEC_CHECKER_TIMEOUT_EN
         wd_q             <= '0;
         timeout_q        <= 1'b0;
`endif
      end else begin
         state_q          <= state_d;
         pass_cnt_q       <= pass_cnt_d;
         fail_cnt_q       <= fail_cnt_d;
         first_fail_q     <= first_fail_d;
         first_fail_idx_q <= first_fail_idx_d;
         idx_q            <= idx_d;
         pass_q           <= pass_d;
`ifdef VEC_CHECKER_TIMEOUT_EN
         wd_q             <= wd_d;
         timeout_q        <= timeout_d;
`endif
      end
   end

   assign in_ready       = (state_q == StRun);
   assign busy           = (state_q == StRun);
   assign done           = (state_q == StDone);
   assign pass           = (state_q == StDone) && pass_q;
   assign pass_cnt       = pass_cnt_q;
   assign fail_cnt       = fail_cnt_q;
   assign first_fail     = first_fail_q;
   assign first_fail_idx = first_fail_idx_q;

endmodule
